host_ctrl: RTL and testbench
============================

Name: host_ctrl

Overview:
Memory-mapped HTIF-style host responder on the CPU data-memory bus (the mem_valid/mem_addr/mem_wstrb/mem_wdata initiator interface). It decodes the tohost/fromhost word pair, answers reads and writes with mem_ready/mem_rdata, and raises halt with an exit code on a terminating tohost write. Console putchar commands go into a small FIFO drained by a UART or simulation sink. It replaces bench-side snooping of tohost with a synthesizable in-SoC endpoint.

Parameters:
HOST_ADDR, 32'h80001000, base byte address; bits [2:0] ignored; word 0 = tohost, word 1 = fromhost
FIFO_DEPTH, 4, console FIFO entries, power of two, at least 2

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
mem_valid  input  1  request valid, held until mem_ready
mem_instr  input  1  request is an instruction fetch
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_wstrb  input  4  byte strobes; 0 = read
mem_ready  output  1  one-cycle response strobe
mem_rdata  output  32  read data, valid while mem_ready=1
halt  output  1  sticky terminate flag
exit_code  output  31  tohost[31:1] captured at halt
con_valid  output  1  console FIFO not empty
con_data  output  8  FIFO head byte
con_ready  input  1  sink pops the head when con_valid & con_ready
fh_wr_valid  input  1  external fromhost write
fh_wr_data  input  32  external fromhost data

Behaviour:
- Reset (reset=0 at posedge): state IDLE; tohost=0, fromhost=0; FIFO empty (pointers and count 0); outputs mem_ready=0, mem_rdata=0, halt=0, exit_code=0, con_valid=0, con_data=0. A reset during RESP or WAIT_FIFO drops the request; no response is issued.
- Hit: mem_valid & (mem_addr[31:3]==HOST_ADDR[31:3]). Non-hit requests are ignored and mem_ready stays 0.
- FSM IDLE -> RESP on a hit. RESP drives mem_ready=1 for exactly one cycle, then returns to IDLE. Latency from mem_valid to mem_ready is 1 cycle minimum. Back-to-back requests are accepted one cycle after mem_ready.
- Read (wstrb=0): mem_rdata = mem_addr[2] ? fromhost : tohost, sampled on the accept cycle.
- mem_instr=1 hit: respond with mem_rdata=0 and no side effects.
- Write: per-byte merge into the addressed register by mem_wstrb. Let V be the merged tohost value. Evaluate V on the accept cycle:
  - V[0]=1: halt<=1, exit_code<=V[31:1], tohost<=V.
  - V[31:16]==16'h0101, FIFO not full: push V[7:0], tohost<=0, fromhost<=32'h01010000.
  - V[31:16]==16'h0101, FIFO full: go to WAIT_FIFO (no mem_ready). Stay there until count<FIFO_DEPTH, then push and go to RESP.
  - Otherwise: tohost<=V only.
- halt is sticky until reset. exit_code never changes once halt=1. Later requests are still answered normally.
- FIFO: circular buffer with wrap-around pointers. Push and pop in the same cycle keep count unchanged, which is legal even when full (in WAIT_FIFO a same-cycle pop frees space for the push next cycle). con_data shows the head combinationally from storage.
- fh_wr_valid: fromhost<=fh_wr_data. If the same cycle also commits a CPU write to fromhost, or the console-ack update of fromhost, the CPU-side update wins.
- All arithmetic is unsigned. The count register is log2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Reset held 3 cycles mid-RESP -> mem_ready, halt, con_valid all 0 after the reset cycle; no response for the dropped request.
- Write 32'h00000001 to HOST_ADDR with wstrb=4'hF -> mem_ready one cycle later, halt=1, exit_code=0. Write 32'h0000002B -> halt=1, exit_code=21, unchanged by a later tohost write.
- Write 32'h01010041 with con_ready=0 -> con_valid=1, con_data=8'h41. Read HOST_ADDR+4 -> mem_rdata=32'h01010000. Read HOST_ADDR -> mem_rdata=0.
- Five putchar writes with DEPTH=4 and con_ready=0 -> fifth write stalls with mem_ready=0 until one pop, then mem_ready; pop order 'A'..'E'.
- Byte write to HOST_ADDR+4 (wstrb=4'b0010, data 32'h0000AB00) in the same cycle as fh_wr_valid with data 32'hFFFFFFFF -> fromhost=32'h0000AB00.
- Non-hit address HOST_ADDR+8 and mem_instr=1 fetch of HOST_ADDR -> no mem_ready for the former; mem_rdata=0 and tohost unchanged for the latter.

Source files
------------

// File: rtl/host_ctrl.sv
// HTIF-style tohost/fromhost responder on the CPU data bus, with a small
// console FIFO fed by putchar commands.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for a request that hits the tohost/fromhost pair
// S_RESP      | mem_ready high for one cycle
// S_WAIT_FIFO | putchar accepted while the console FIFO is full; waiting
//             | for room, then push and respond
module host_ctrl #(
  parameter logic [31:0] HOST_ADDR  = 32'h80001000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        halt,
  output logic [30:0] exit_code,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  input  logic        fh_wr_valid,
  input  logic [31:0] fh_wr_data
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WAIT_FIFO} state_t;

  state_t        state, state_nxt;
  logic [31:0]   tohost, fromhost, rdata_q, rdata_nxt;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    pend_byte, push_byte;
  logic [31:0]   v_to, v_from, to_nxt, from_cpu_nxt;
  logic          hit, fifo_full, push, pop, to_we, from_cpu_we, halt_set, pend_we;
  logic          addr_unused;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    return r;
  endfunction

  assign addr_unused = &mem_addr[1:0];
  assign hit         = mem_valid && (mem_addr[31:3] == HOST_ADDR[31:3]);
  assign fifo_full   = (count == DEPTH_C);
  assign pop         = (count != '0) && con_ready;
  assign v_to        = merge_bytes(tohost, mem_wdata, mem_wstrb);
  assign v_from      = merge_bytes(fromhost, mem_wdata, mem_wstrb);

  always_comb begin
    state_nxt    = state;
    rdata_nxt    = rdata_q;
    push         = 1'b0;
    push_byte    = v_to[7:0];
    to_we        = 1'b0;
    to_nxt       = v_to;
    from_cpu_we  = 1'b0;
    from_cpu_nxt = v_from;
    halt_set     = 1'b0;
    pend_we      = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          state_nxt = S_RESP;
          rdata_nxt = '0;
          if (mem_instr) begin
            rdata_nxt = '0;
          end else if (mem_wstrb == 4'h0) begin
            rdata_nxt = mem_addr[2] ? fromhost : tohost;
          end else if (mem_addr[2]) begin
            from_cpu_we = 1'b1;
          end else if (v_to[31:16] == 16'h0101) begin
            // putchar takes precedence over the halt bit: the char's LSB may be set
            if (fifo_full) begin
              state_nxt = S_WAIT_FIFO;
              pend_we   = 1'b1;
            end else begin
              push         = 1'b1;
              to_we        = 1'b1;
              to_nxt       = '0;
              from_cpu_we  = 1'b1;
              from_cpu_nxt = 32'h01010000;
            end
          end else begin
            to_we    = 1'b1;
            halt_set = v_to[0];
          end
        end
      end
      S_RESP: state_nxt = S_IDLE;
      S_WAIT_FIFO: begin
        if (!fifo_full) begin
          state_nxt    = S_RESP;
          push         = 1'b1;
          push_byte    = pend_byte;
          to_we        = 1'b1;
          to_nxt       = '0;
          from_cpu_we  = 1'b1;
          from_cpu_nxt = 32'h01010000;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      tohost    <= '0;
      fromhost  <= '0;
      rdata_q   <= '0;
      halt      <= 1'b0;
      exit_code <= '0;
      pend_byte <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      if (to_we) tohost <= to_nxt;
      // CPU-side updates of fromhost win over the external writer
      if (from_cpu_we)      fromhost <= from_cpu_nxt;
      else if (fh_wr_valid) fromhost <= fh_wr_data;
      if (halt_set && !halt) begin
        halt      <= 1'b1;
        exit_code <= to_nxt[31:1];
      end
      if (pend_we) pend_byte <= v_to[7:0];
      if (push) begin
        fifo_mem[wr_ptr] <= push_byte;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  assign mem_ready = (state == S_RESP);
  assign mem_rdata = mem_ready ? rdata_q : '0;
  assign con_valid = (count != '0);
  assign con_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_host_ctrl.sv
// Scoreboard bench for host_ctrl: directed scenarios followed by random
// bus traffic checked against a register-level model of tohost/fromhost.
module tb_host_ctrl;
  localparam logic [31:0] HA = 32'h80001000;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        halt;
  logic [30:0] exit_code;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        fh_wr_valid;
  logic [31:0] fh_wr_data;

  always #5 clock = ~clock;

  host_ctrl #(.HOST_ADDR(HA), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .halt(halt), .exit_code(exit_code),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .fh_wr_valid(fh_wr_valid), .fh_wr_data(fh_wr_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_to, m_from;
  logic        m_halt;
  logic [30:0] m_exit;
  logic [7:0]  exp_con[$];
  logic [31:0] exp_d[$];
  bit          exp_chk[$];
  int          sink_mode = 0;  // 0 off, 1 random, 2 single pop

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_to = '0; m_from = '0; m_halt = 1'b0; m_exit = '0;
    exp_con.delete(); exp_d.delete(); exp_chk.delete();
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic ins);
    logic [31:0] v;
    if (a[31:3] == HA[31:3]) begin
      if (ins) begin
        exp_d.push_back(32'h0); exp_chk.push_back(1'b1);
      end else if (s == 4'h0) begin
        exp_d.push_back(a[2] ? m_from : m_to); exp_chk.push_back(1'b1);
      end else begin
        exp_d.push_back(32'h0); exp_chk.push_back(1'b0);
        if (a[2]) m_from = merge(m_from, d, s);
        else begin
          v = merge(m_to, d, s);
          if (v[31:16] == 16'h0101) begin
            exp_con.push_back(v[7:0]);
            m_to = '0;
            m_from = 32'h01010000;
          end else begin
            m_to = v;
            if (v[0] && !m_halt) begin m_halt = 1'b1; m_exit = v[31:1]; end
          end
        end
      end
    end
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
  endtask

  task automatic wait_rsp(input int max, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      fh_wr_valid = 1'b0;
      if (mem_ready) begin lat = i; got = 1'b1; break; end
    end
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    check("rsp_seen", 32'(got), 32'd1);
    @(negedge clock);
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic ins, output int lat);
    drive_req(a, d, s, ins);
    wait_rsp(300, lat);
  endtask

  task automatic nohit(input logic [31:0] a);
    drive_req(a, $urandom, 4'h0, 1'b0);
    repeat (3) begin
      @(negedge clock);
      check("nohit_ready", 32'(mem_ready), 32'd0);
    end
    mem_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic fh_write(input logic [31:0] d);
    fh_wr_valid = 1'b1; fh_wr_data = d;
    @(negedge clock);
    fh_wr_valid = 1'b0;
    m_from = d;
  endtask

  task automatic do_reset(input int n);
    sink_mode = 0;
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0; fh_wr_valid = 1'b0;
    reset = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_exit_code", 32'(exit_code), 32'd0);
    check("rst_con_valid", 32'(con_valid), 32'd0);
    check("rst_con_data", 32'(con_data), 32'd0);
  endtask

  task automatic check_status();
    check("halt", 32'(halt), 32'(m_halt));
    check("exit_code", 32'(exit_code), 32'(m_exit));
  endtask

  task automatic drain();
    sink_mode = 1;
    for (int i = 0; i < 300 && exp_con.size() != 0; i++) @(negedge clock);
    sink_mode = 0;
    check("con_drained", 32'(exp_con.size()), 32'd0);
    @(negedge clock);
    check("con_empty", 32'(con_valid), 32'd0);
  endtask

  // response monitor
  always @(negedge clock) begin
    if (mem_ready) begin
      if (exp_d.size() == 0) check("unexpected_ready", 32'(mem_ready), 32'd0);
      else begin
        logic [31:0] d;
        bit c;
        d = exp_d.pop_front();
        c = exp_chk.pop_front();
        if (c) check("rdata", mem_rdata, d);
      end
    end
  end

  // console sink and byte-order monitor
  always @(negedge clock) begin
    if (sink_mode == 0)      con_ready = 1'b0;
    else if (sink_mode == 2) con_ready = con_valid;
    else                     con_ready = 1'($urandom_range(0, 1));
    if (con_ready && con_valid) begin
      if (exp_con.size() == 0) check("unexpected_pop", 32'(con_valid), 32'd0);
      else check("con_data", 32'(con_data), 32'(exp_con.pop_front()));
      if (sink_mode == 2) sink_mode = 0;
    end
  end

  initial begin
    int lat;
    logic [7:0] ch;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    fh_wr_valid = 1'b0; fh_wr_data = '0; con_ready = 1'b0; reset = 1'b0;
    model_reset();
    do_reset(3);
    check_reset_outputs();

    // halt with exit code 0, then 21 which must stay put
    bus(HA, 32'h00000001, 4'hF, 1'b0, lat);
    check("halt_latency", 32'(lat), 32'd1);
    check("halt_set", 32'(halt), 32'd1);
    check("halt_exit0", 32'(exit_code), 32'd0);
    do_reset(1);
    bus(HA, 32'h0000002B, 4'hF, 1'b0, lat);
    check("exit21", 32'(exit_code), 32'd21);
    bus(HA, 32'h00000045, 4'hF, 1'b0, lat);
    check("exit21_sticky", 32'(exit_code), 32'd21);
    check("halt_sticky", 32'(halt), 32'd1);
    bus(HA, 32'h0, 4'h0, 1'b0, lat);
    check_status();

    // putchar and fromhost ack
    do_reset(1);
    bus(HA, 32'h01010041, 4'hF, 1'b0, lat);
    check("putc_con_valid", 32'(con_valid), 32'd1);
    check("putc_con_data", 32'(con_data), 32'h41);
    check("putc_no_halt", 32'(halt), 32'd0);
    bus(HA + 32'd4, 32'h0, 4'h0, 1'b0, lat);
    bus(HA, 32'h0, 4'h0, 1'b0, lat);

    // fill FIFO, fifth putchar stalls until one pop
    for (int i = 1; i < 4; i++) bus(HA, {16'h0101, 8'h00, 8'(8'h41 + i)}, 4'hF, 1'b0, lat);
    drive_req(HA, 32'h01010045, 4'hF, 1'b0);
    repeat (5) begin
      @(negedge clock);
      check("stall_no_ready", 32'(mem_ready), 32'd0);
    end
    sink_mode = 2;
    wait_rsp(50, lat);
    drain();

    // reset while stalled in the FIFO wait drops the request
    do_reset(1);
    for (int i = 0; i < 4; i++) bus(HA, {16'h0101, 8'h00, 8'(8'h61 + i)}, 4'hF, 1'b0, lat);
    drive_req(HA, 32'h01010065, 4'hF, 1'b0);
    repeat (3) @(negedge clock);
    do_reset(3);
    check_reset_outputs();
    repeat (3) begin
      @(negedge clock);
      check("dropped_no_ready", 32'(mem_ready), 32'd0);
    end

    // CPU byte write to fromhost beats same-cycle external write
    drive_req(HA + 32'd4, 32'h0000AB00, 4'b0010, 1'b0);
    fh_wr_valid = 1'b1; fh_wr_data = 32'hFFFFFFFF;
    wait_rsp(20, lat);
    bus(HA + 32'd4, 32'h0, 4'h0, 1'b0, lat);
    fh_write(32'h12345678);
    bus(HA + 32'd4, 32'h0, 4'h0, 1'b0, lat);

    // non-hit and instruction fetch
    bus(HA, 32'h00000010, 4'hF, 1'b0, lat);
    nohit(HA + 32'd8);
    bus(HA, 32'hDEADBEEF, 4'hF, 1'b1, lat);
    bus(HA, 32'h0, 4'h0, 1'b0, lat);
    check_status();

    // random traffic
    do_reset(1);
    sink_mode = 1;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: bus(HA + (($urandom_range(0, 1)) << 2), 32'h0, 4'h0, 1'b0, lat);
        1: bus(HA + 32'(($urandom_range(0, 1)) << 2 | $urandom_range(0, 3)), $urandom,
               4'($urandom_range(1, 15)), 1'b0, lat);
        2: begin
          ch = 8'($urandom_range(32, 126));
          bus(HA, {16'h0101, 8'h00, ch}, 4'hF, 1'b0, lat);
        end
        3: bus(HA + 32'd4, $urandom, 4'($urandom_range(1, 15)), 1'b0, lat);
        4: fh_write($urandom);
        5: bus(HA + (($urandom_range(0, 1)) << 2), $urandom, 4'($urandom_range(0, 15)), 1'b1, lat);
        default: nohit(HA + 32'd8 * 32'($urandom_range(1, 1000)));
      endcase
      check_status();
    end
    bus(HA, 32'h0, 4'h0, 1'b0, lat);
    bus(HA + 32'd4, 32'h0, 4'h0, 1'b0, lat);
    drain();
    check("rsp_queue_empty", 32'(exp_d.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
